// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - CPU-side memory responder with programmable MFC latency
//
// Purpose: accepts a single read or write request from the CPU controller,
// waits LATENCY cycles, performs the access on an internal 2**AW x 16 word
// array and raises MFC until the controller drops its request.
//
// Ports:
//   clock  - system clock, all state changes on posedge
//   reset  - synchronous, active-high; clears state, outputs and memory
//   read   - read request, held high until MFC seen
//   write  - write request, held high until MFC seen
//   addr   - 16-bit word address (MAR)
//   wdata  - 16-bit write data (MDR)
//   rdata  - registered read data
//   MFC    - registered memory function complete
//   busy   - high whenever the FSM is not IDLE
//   err    - registered fault flag (conflicting request or out-of-range address)

module memory_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        MFC,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        op_write_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        mfc_q;
    logic        err_q;
    logic [15:0] mem_q [DEPTH];

    logic          req_active;
    logic          addr_oob;
    logic [AW-1:0] mem_idx;

    // The transaction lives only as long as the request line of the latched
    // operation stays high; the other request line is ignored once accepted.
    assign req_active = op_write_q ? write : read;
    // Any set bit above the implemented address range is a fault.
    assign addr_oob   = (addr_q >> AW) != 16'h0000;
    assign mem_idx    = addr_q[AW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rdata_q    <= 16'h0000;
            mfc_q      <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    mfc_q <= 1'b0;
                    // Conflicting request: one-cycle error pulse, no acceptance.
                    err_q <= read & write;
                    if (read ^ write) begin
                        op_write_q <= write;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        cnt_q      <= 4'(LATENCY);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req_active) begin
                        // Controller withdrew: abort with no side effects.
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        mfc_q   <= 1'b1;
                        err_q   <= addr_oob;
                        if (op_write_q) begin
                            if (!addr_oob) begin
                                mem_q[mem_idx] <= wdata_q;
                            end
                        end else begin
                            rdata_q <= addr_oob ? 16'h0000 : mem_q[mem_idx];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here guarantees one idle cycle before
                    // the next request can be accepted.
                    if (!req_active) begin
                        state_q <= IDLE;
                        mfc_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mfc_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign MFC   = mfc_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder

module tb_memory_responder;

    logic        clock;
    logic        reset;

    logic        read_a, write_a;
    logic [15:0] addr_a, wdata_a, rdata_a;
    logic        mfc_a, busy_a, err_a;

    logic        read_b, write_b;
    logic [15:0] addr_b, wdata_b, rdata_b;
    logic        mfc_b, busy_b, err_b;

    int tests_run;
    int tests_failed;

    memory_responder #(.LATENCY(2), .AW(8)) dut_a (
        .clock (clock),
        .reset (reset),
        .read  (read_a),
        .write (write_a),
        .addr  (addr_a),
        .wdata (wdata_a),
        .rdata (rdata_a),
        .MFC   (mfc_a),
        .busy  (busy_a),
        .err   (err_a)
    );

    memory_responder #(.LATENCY(0), .AW(8)) dut_b (
        .clock (clock),
        .reset (reset),
        .read  (read_b),
        .write (write_b),
        .addr  (addr_b),
        .wdata (wdata_b),
        .rdata (rdata_b),
        .MFC   (mfc_b),
        .busy  (busy_b),
        .err   (err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        read_a  = 1'b0; write_a = 1'b0; addr_a = 16'h0; wdata_a = 16'h0;
        read_b  = 1'b0; write_b = 1'b0; addr_b = 16'h0; wdata_b = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_mfc",   16'(mfc_a),  16'h0);
        check("rst_err",   16'(err_a),  16'h0);
        check("rst_busy",  16'(busy_a), 16'h0);
        check("rst_rdata", rdata_a,     16'h0000);
        tick();

        // Write A5C3 to word 5; edge 0 accepts, MFC rises after edge 3.
        write_a = 1'b1; addr_a = 16'h0005; wdata_a = 16'hA5C3;
        tick();                                   // edge 0
        check("wr_busy_e0", 16'(busy_a), 16'h1);
        check("wr_mfc_e0",  16'(mfc_a),  16'h0);
        addr_a = 16'h0007; wdata_a = 16'hFFFF;    // must not affect transaction
        tick();                                   // edge 1
        check("wr_mfc_e1",  16'(mfc_a),  16'h0);
        tick();                                   // edge 2
        check("wr_mfc_e2",  16'(mfc_a),  16'h0);
        tick();                                   // edge 3
        check("wr_mfc_e3",  16'(mfc_a),  16'h1);
        check("wr_err_e3",  16'(err_a),  16'h0);
        check("wr_rdata",   rdata_a,     16'h0000);
        tick();
        check("wr_mfc_hold", 16'(mfc_a), 16'h1);
        // Drop write and raise read together: MFC clears, read not accepted yet.
        write_a = 1'b0; read_a = 1'b1; addr_a = 16'h0005;
        tick();
        check("wr_mfc_clr",  16'(mfc_a),  16'h0);
        check("wr_busy_clr", 16'(busy_a), 16'h0);
        tick();                                   // read edge 0
        check("rd_busy_e0",  16'(busy_a), 16'h1);
        tick();
        tick();
        check("rd_mfc_e2",   16'(mfc_a),  16'h0);
        tick();                                   // edge 3
        check("rd_mfc_e3",   16'(mfc_a),  16'h1);
        check("rd_rdata5",   rdata_a,     16'hA5C3);
        check("rd_err",      16'(err_a),  16'h0);
        read_a = 1'b0;
        tick();
        check("rd_mfc_clr",  16'(mfc_a),  16'h0);
        check("rd_rdata_hold", rdata_a,   16'hA5C3);
        tick();

        // Unwritten word 6 reads zero.
        read_a = 1'b1; addr_a = 16'h0006;
        repeat (4) tick();
        check("rd6_mfc",   16'(mfc_a), 16'h1);
        check("rd6_rdata", rdata_a,    16'h0000);
        read_a = 1'b0;
        tick();
        tick();

        // Conflicting request: one-cycle err pulse, nothing accepted.
        read_a = 1'b1; write_a = 1'b1; addr_a = 16'h0005; wdata_a = 16'h1234;
        tick();
        check("both_err",  16'(err_a),  16'h1);
        check("both_mfc",  16'(mfc_a),  16'h0);
        check("both_busy", 16'(busy_a), 16'h0);
        read_a = 1'b0; write_a = 1'b0;
        tick();
        check("both_err_clr", 16'(err_a), 16'h0);

        // Out-of-range read.
        read_a = 1'b1; addr_a = 16'h0105;
        tick();
        tick();
        tick();
        check("oob_rd_mfc_e2", 16'(mfc_a), 16'h0);
        tick();
        check("oob_rd_mfc",   16'(mfc_a), 16'h1);
        check("oob_rd_err",   16'(err_a), 16'h1);
        check("oob_rd_rdata", rdata_a,    16'h0000);
        tick();
        check("oob_rd_err_hold", 16'(err_a), 16'h1);
        read_a = 1'b0;
        tick();
        check("oob_rd_err_clr", 16'(err_a), 16'h0);
        check("oob_rd_mfc_clr", 16'(mfc_a), 16'h0);
        tick();

        // Out-of-range write is discarded and leaves rdata alone.
        write_a = 1'b1; addr_a = 16'h0105; wdata_a = 16'hBEEF;
        repeat (4) tick();
        check("oob_wr_mfc",   16'(mfc_a), 16'h1);
        check("oob_wr_err",   16'(err_a), 16'h1);
        check("oob_wr_rdata", rdata_a,    16'h0000);
        write_a = 1'b0;
        tick();
        tick();

        // Word 5 still holds A5C3 after conflict and out-of-range write.
        read_a = 1'b1; addr_a = 16'h0005;
        repeat (4) tick();
        check("rd5_again", rdata_a, 16'hA5C3);
        read_a = 1'b0;
        tick();
        tick();

        // Read withdrawn one edge after acceptance aborts.
        read_a = 1'b1; addr_a = 16'h0006;
        tick();                                   // accept
        read_a = 1'b0;
        tick();
        check("abort_busy", 16'(busy_a), 16'h0);
        check("abort_mfc",  16'(mfc_a),  16'h0);
        tick();
        tick();
        check("abort_mfc_late", 16'(mfc_a), 16'h0);
        check("abort_rdata",    rdata_a,    16'hA5C3);

        // Reset in WAIT of a write.
        write_a = 1'b1; addr_a = 16'h0009; wdata_a = 16'h5555;
        tick();                                   // accept
        reset = 1'b1;
        tick();
        check("rstw_mfc",  16'(mfc_a),  16'h0);
        check("rstw_busy", 16'(busy_a), 16'h0);
        reset = 1'b0; write_a = 1'b0;
        tick();
        tick();
        check("rstw_mfc_late", 16'(mfc_a), 16'h0);
        read_a = 1'b1; addr_a = 16'h0009;
        repeat (4) tick();
        check("rstw_rd9_mfc", 16'(mfc_a), 16'h1);
        check("rstw_rd9",     rdata_a,    16'h0000);
        read_a = 1'b0;
        tick();
        tick();
        read_a = 1'b1; addr_a = 16'h0005;
        repeat (4) tick();
        check("rst_cleared5", rdata_a, 16'h0000);
        read_a = 1'b0;
        tick();

        // LATENCY=0 instance.
        write_b = 1'b1; addr_b = 16'h0003; wdata_b = 16'h1357;
        tick();                                   // edge 0
        check("l0_wr_mfc_e0", 16'(mfc_b), 16'h0);
        tick();                                   // edge 1
        check("l0_wr_mfc_e1", 16'(mfc_b), 16'h1);
        write_b = 1'b0;
        tick();
        tick();
        read_b = 1'b1;
        tick();                                   // edge 0
        check("l0_rd_mfc_e0", 16'(mfc_b), 16'h0);
        tick();                                   // edge 1
        check("l0_rd_mfc_e1", 16'(mfc_b), 16'h1);
        check("l0_rd_rdata",  rdata_b,    16'h1357);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("l0_rd_mfc_hold", 16'(mfc_b), 16'h1);
        end
        read_b = 1'b0;
        tick();
        check("l0_rd_mfc_clr", 16'(mfc_b),  16'h0);
        check("l0_busy_clr",   16'(busy_b), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
